// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: default widths, reset PC and instruction field layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_pkg;

  localparam int IF_PC_W     = 8;
  localparam int IF_INST_W   = 16;
  localparam int IF_RESET_PC = 0;

  // Number of words the fetch queue can hold; issue is throttled against this.
  localparam int FQ_DEPTH = 2;

  // Instruction field bit positions, shared with the decoder.
  localparam int COND_HI    = 15;
  localparam int COND_LO    = 14;
  localparam int OPCD_HI    = 13;
  localparam int OPCD_LO    = 9;
  localparam int DEST_HI    = 8;
  localparam int DEST_LO    = 6;
  localparam int SOURCE_HI  = 5;
  localparam int SOURCE_LO  = 3;
  localparam int SOURCE2_HI = 2;
  localparam int SOURCE2_LO = 0;

  typedef struct packed {
    logic [COND_HI-COND_LO:0]       cond;
    logic [OPCD_HI-OPCD_LO:0]       opcd;
    logic [DEST_HI-DEST_LO:0]       dest;
    logic [SOURCE_HI-SOURCE_LO:0]   source;
    logic [SOURCE2_HI-SOURCE2_LO:0] source2;
  } inst_fields_t;

  function automatic inst_fields_t split_fields(input logic [IF_INST_W-1:0] word);
    return inst_fields_t'(word);
  endfunction

endpackage

// File: rtl/instr_fetch_fetch_queue.sv
// 2-entry FIFO holding fetched {pc, inst} words for the decoder.
// Latency: push visible at head the cycle after it is written; head is registered.
// Backpressure: head held while pop=0; a push into a full queue is ignored unless a pop frees a slot.
//
// Ports: clk, rst_n (sync, active-low), flush (empties queue), push/push_data,
//        pop, count (0..2), head_valid, head_data.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int W = IF_PC_W + IF_INST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem [FQ_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (cnt != 2'd0);
  // A full queue can still take a word when the head leaves in the same cycle.
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign count      = cnt;
  assign head_valid = (cnt != 2'd0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, ROM read issue and a 2-entry queue feeding the decoder.
// Latency: rom_en in cycle N -> rom_data N+1 -> inst_valid N+2; 1 inst/cycle sustained.
// Backpressure: stall holds the head; issue stops once queued + in-flight words reach 2.
//
// Ports: clk, rst_n (sync, active-low); rom_en/rom_addr/rom_data (sync ROM, 1-cycle read);
//        stall (decoder busy); redirect/redirect_pc (flush and load PC);
//        inst/inst_pc/inst_valid (queue head, zeroed when empty).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          PC_W     = IF_PC_W,
  parameter int          INST_W   = IF_INST_W,
  parameter int unsigned RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid
);

  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        issued_pc;
  logic                   inflight;
  logic [1:0]             count;
  logic                   head_valid;
  logic [PC_W+INST_W-1:0] head_data;
  logic [PC_W+INST_W-1:0] push_data;
  logic                   pop;
  logic                   push;
  logic [2:0]             occ_after_pop;

  // Redirect suppresses both consumption and the returning word: everything
  // fetched before the redirect belongs to the wrong path.
  assign pop  = head_valid & ~stall & ~redirect;
  assign push = inflight & ~redirect;

  // Words that will still occupy the queue next cycle, counting the one in
  // flight; a new read is only issued if its return is guaranteed a slot.
  assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rom_en        = rst_n & ~redirect & (occ_after_pop < 3'(FQ_DEPTH));
  assign rom_addr      = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= PC_W'(RESET_PC);
      issued_pc <= '0;
      inflight  <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        pc        <= pc + PC_W'(1);
        issued_pc <= pc;
      end
    end
  end

  assign push_data = {issued_pc, rom_data};

  fetch_queue #(
    .W(PC_W + INST_W)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head_valid(head_valid),
    .head_data (head_data)
  );

  assign inst_valid = head_valid;
  assign inst       = head_valid ? head_data[INST_W-1:0] : '0;
  assign inst_pc    = head_valid ? head_data[PC_W+INST_W-1:INST_W] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle synchronous ROM model (ROM[i] = 0x0100 + i).
// Latency: n/a.
// Backpressure: stall driven directly by the scenarios.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= 16'h0100 + {8'h00, rom_addr};
  end

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  // Leaves the caller at the negedge of cycle C0: rst_n just went high, no sample yet.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 8'h0 || rom_en !== 1'b0) begin
      failures++;
      $display("FAIL reset: got v=%b inst=%h pc=%h rom_en=%b, want 0 0000 00 0", inst_valid, inst, inst_pc, rom_en);
    end
  endtask

  task automatic test_free_run();
    do_reset(); #1;
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin
      failures++; $display("FAIL free_first_issue: got en=%b addr=%h, want 1 00", rom_en, rom_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h01) begin
      failures++; $display("FAIL free_c1: got v=%b en=%b addr=%h, want 0 1 01", inst_valid, rom_en, rom_addr);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 16'h0100 + 16'(k) || inst_pc !== 8'(k) ||
          rom_en !== 1'b1 || rom_addr !== 8'(k + 2)) begin
        failures++;
        $display("FAIL free_run[%0d]: got v=%b inst=%h pc=%h en=%b addr=%h, want 1 %h %h 1 %h",
                 k, inst_valid, inst, inst_pc, rom_en, rom_addr, 16'h0100 + 16'(k), 8'(k), 8'(k + 2));
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_inst [3] = '{16'h0102, 16'h0103, 16'h0104};
    logic [7:0]  exp_addr [3] = '{8'h04, 8'h05, 8'h06};
    do_reset();
    for (int c = 1; c <= 3; c++) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); stall = 1'b1; #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 16'h0102 || inst_pc !== 8'h02 || rom_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h en=%b, want 1 0102 02 0", s, inst_valid, inst, inst_pc, rom_en);
      end
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); stall = 1'b0; #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== exp_inst[r] || inst_pc !== 8'(r + 2) ||
          rom_en !== 1'b1 || rom_addr !== exp_addr[r]) begin
        failures++;
        $display("FAIL stall_release[%0d]: got v=%b inst=%h pc=%h en=%b addr=%h, want 1 %h %h 1 %h",
                 r, inst_valid, inst, inst_pc, rom_en, rom_addr, exp_inst[r], 8'(r + 2), exp_addr[r]);
      end
    end
  endtask

  // Shared tail of every redirect scenario: two empty cycles while the new
  // path refills, then n words starting at target.
  task automatic check_restart(input string name, input logic [7:0] target, input int n);
    logic [7:0] p;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); redirect = 1'b0; stall = 1'b0; #1;
      checks++;
      if (inst_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== target + 8'(c)) begin
        failures++;
        $display("FAIL %s_gap[%0d]: got v=%b pc=%h en=%b addr=%h, want 0 - 1 %h",
                 name, c, inst_valid, inst_pc, rom_en, rom_addr, target + 8'(c));
      end
    end
    for (int k = 0; k < n; k++) begin
      p = target + 8'(k);
      @(negedge clk); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== p || inst !== 16'h0100 + {8'h00, p}) begin
        failures++;
        $display("FAIL %s_seq[%0d]: got v=%b inst=%h pc=%h, want 1 %h %h",
                 name, k, inst_valid, inst, inst_pc, 16'h0100 + {8'h00, p}, p);
      end
    end
  endtask

  task automatic test_redirect();
    @(negedge clk); redirect = 1'b1; redirect_pc = 8'h40; #1;
    checks++;
    if (rom_en !== 1'b0) begin
      failures++; $display("FAIL redirect_issue: got en=%b, want 0", rom_en);
    end
    check_restart("redirect", 8'h40, 2);
  endtask

  task automatic test_redirect_stall();
    @(negedge clk); stall = 1'b1; #1;
    @(negedge clk); stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h80; #1;
    checks++;
    if (rom_en !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 8'h42) begin
      failures++;
      $display("FAIL redir_stall_cycle: got en=%b v=%b pc=%h, want 0 1 42", rom_en, inst_valid, inst_pc);
    end
    check_restart("redir_stall", 8'h80, 2);
  endtask

  task automatic test_wrap();
    @(negedge clk); redirect = 1'b1; redirect_pc = 8'hFE; #1;
    checks++;
    if (rom_en !== 1'b0) begin
      failures++; $display("FAIL wrap_issue: got en=%b, want 0", rom_en);
    end
    check_restart("wrap", 8'hFE, 4);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); stall = 1'b1; #1;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: got v=%b, want 1", inst_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 8'h0 || rom_en !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_cleared: got v=%b inst=%h pc=%h en=%b, want 0 0000 00 0", inst_valid, inst, inst_pc, rom_en);
    end
    rst_n = 1'b1; stall = 1'b0; #1;
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h00) begin
      failures++; $display("FAIL rstmid_issue: got en=%b addr=%h, want 1 00", rom_en, rom_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 8'h01) begin
      failures++; $display("FAIL rstmid_c1: got v=%b addr=%h, want 0 01", inst_valid, rom_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 16'h0100 || inst_pc !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_first: got v=%b inst=%h pc=%h, want 1 0100 00", inst_valid, inst, inst_pc);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
